ifetch_unit: RTL and testbench

- Instruction fetch stage that consumes the address stream from the PC stage and issues word reads to instruction memory over a req/gnt/rvalid bus.
- Buffers returned instructions with their PCs in an in-order queue and delivers them to decode over valid/ready.
- Discards queued and in-flight fetches on a redirect (flush), which is asserted in the same cycle as the PC stage's jump.

---
 rtl/rv32_pkg.sv | 28 ++
 rtl/ifetch_unit_if.sv | 49 ++++
 rtl/fetch_entry_queue.sv | 79 +++++++
 rtl/ifetch_unit.sv | 116 +++++++++++
 tb/tb_ifetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pkg
// Brief    : Shared RV32 widths, constants and the fetch queue entry type.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] RV32_NOP = 32'h00000013;

  // One fetch queue slot: the PC it was fetched from, the returned word and
  // whether memory has answered yet.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] data;
    logic            filled;
  } fetch_entry_t;

  // Instruction memory is word addressed; the low byte-offset bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit_if
// Brief    : PC-stage, instruction-memory and decode handshakes of the
//            fetch unit, bundled with fetch-unit and environment views.
// Revision : 1.0 - initial release
// ============================================================================
interface ifetch_unit_if;
  import rv32_pkg::*;

  // PC stage
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_valid;
  logic            fetch_ready;
  logic            flush;

  // Instruction memory
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;

  // Decode
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  // Fetch unit side
  modport master (
    input  fetch_addr, fetch_valid, flush,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  inst_ready,
    output fetch_ready, imem_req, imem_addr,
    output inst_valid, inst_data, inst_pc
  );

  // PC stage / memory / decode side
  modport slave (
    output fetch_addr, fetch_valid, flush,
    output imem_gnt, imem_rvalid, imem_rdata,
    output inst_ready,
    input  fetch_ready, imem_req, imem_addr,
    input  inst_valid, inst_data, inst_pc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_entry_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_entry_queue
// Brief    : In-order fetch slot storage. Slots are allocated at request
//            acceptance, filled by in-order memory responses and popped by
//            decode. Three pointers: write (alloc), response (fill), read.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_entry_queue
  import rv32_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic             fill,
  input  logic [ILEN-1:0]  fill_data,
  input  logic             pop,
  input  logic             clear,
  output fetch_entry_t     head_entry,
  output logic [DEPTH-1:0] filled_vec
);

  fetch_entry_t     r_entries [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_rsp_ptr;

  // Slot and pointer update; DEPTH is a power of two so pointers wrap freely.
  // Fill and pop never hit the same slot: fill targets the oldest unfilled
  // slot, pop only ever takes a filled one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rsp_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else if (clear) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rsp_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].filled <= 1'b0;
      end
    end else begin
      if (alloc) begin
        r_entries[r_wr_ptr].pc     <= alloc_pc;
        r_entries[r_wr_ptr].filled <= 1'b0;
        r_wr_ptr                   <= r_wr_ptr + 1'b1;
      end
      if (fill) begin
        r_entries[r_rsp_ptr].data   <= fill_data;
        r_entries[r_rsp_ptr].filled <= 1'b1;
        r_rsp_ptr                   <= r_rsp_ptr + 1'b1;
      end
      if (pop) begin
        r_entries[r_rd_ptr].filled <= 1'b0;
        r_rd_ptr                   <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Expose every filled bit so the parent can count unanswered slots.
  always_comb begin
    filled_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_vec[i] = r_entries[i].filled;
    end
  end

  assign head_entry = r_entries[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Brief    : Instruction fetch stage. Issues word reads for the PC stream,
//            queues returned words with their PCs and hands them to decode.
//            A redirect kills queued and in-flight fetches; responses still
//            owed for killed fetches are swallowed via a drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit
  import rv32_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_unit_if.master bus
);

  localparam logic [PTR_W+1:0] c_depth = (PTR_W+2)'(DEPTH);

  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   r_drop_cnt;

  logic [PTR_W+1:0] w_occupancy;
  logic             w_space;
  logic             w_req;
  logic             w_accept;
  logic             w_fill;
  logic             w_drop_rsp;
  logic             w_inst_valid;
  logic             w_pop;
  logic [PTR_W:0]   w_filled_cnt;
  logic [PTR_W:0]   w_unfilled;
  logic [PTR_W:0]   w_rvalid_ext;
  logic [DEPTH-1:0] w_filled_vec;
  fetch_entry_t     w_head;

  // Killed-but-unanswered fetches still hold memory slots, so they count
  // against the credit together with live queue entries.
  assign w_occupancy = {1'b0, r_count} + {1'b0, r_drop_cnt};
  assign w_space     = (w_occupancy < c_depth);

  // Request path; gated by reset so every output is quiet during reset.
  assign w_req           = reset & bus.fetch_valid & w_space & ~bus.flush;
  assign w_accept        = w_req & bus.imem_gnt;
  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = reset ? word_align(bus.fetch_addr) : '0;
  assign bus.fetch_ready = w_accept;

  // Responses land in the queue only once all killed fetches are drained.
  assign w_fill       = bus.imem_rvalid & (r_drop_cnt == '0) & ~bus.flush;
  assign w_drop_rsp   = bus.imem_rvalid & (r_drop_cnt != '0);
  assign w_rvalid_ext = {{PTR_W{1'b0}}, bus.imem_rvalid};

  // Decode side; the head is offered only once its word has arrived.
  assign w_inst_valid   = (r_count != '0) & w_head.filled & ~bus.flush;
  assign w_pop          = w_inst_valid & bus.inst_ready;
  assign bus.inst_valid = w_inst_valid;
  assign bus.inst_data  = w_head.data;
  assign bus.inst_pc    = w_head.pc;

  // Count answered slots so a redirect knows how many responses are owed.
  always_comb begin
    w_filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_filled_cnt = w_filled_cnt + {{PTR_W{1'b0}}, w_filled_vec[i]};
    end
  end

  assign w_unfilled = r_count - w_filled_cnt;

  // Live entry count: accepts minus pops, emptied by a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (bus.flush) begin
      r_count <= '0;
    end else if (w_accept && !w_pop) begin
      r_count <= r_count + 1'b1;
    end else if (!w_accept && w_pop) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Responses still owed for killed fetches. A response arriving in the
  // flush cycle answers one of them (either an older drop or an unfilled
  // entry), hence the single subtraction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (bus.flush) begin
      r_drop_cnt <= r_drop_cnt + w_unfilled - w_rvalid_ext;
    end else if (w_drop_rsp) begin
      r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  fetch_entry_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .alloc      (w_accept),
    .alloc_pc   (bus.fetch_addr),
    .fill       (w_fill),
    .fill_data  (bus.imem_rdata),
    .pop        (w_pop),
    .clear      (bus.flush),
    .head_entry (w_head),
    .filled_vec (w_filled_vec)
  );

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Brief    : Scoreboard bench for ifetch_unit with an in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  int          rv_cyc_q[$];
  bit          lat_mode = 1'b0;
  bit          auto_rsp = 1'b1;
  int          rel_cnt = 0;
  int          rel_used = 0;
  bit          toggle_mode = 1'b0;
  logic        rdy_level = 1'b0;
  bit          prev_stall = 1'b0;
  int          mdl_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Memory contents: a few listed words, everything else a tagged address.
  function automatic logic [31:0] mdata(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h0020_81B3;
      32'h0000_0100: return 32'h0000_0013;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // In-order memory: capture accepted requests, answer one per cycle at
  // least one cycle later, either freely or only against release credits.
  initial begin
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset && bus.imem_req && bus.imem_gnt) pend_q.push_back(bus.imem_addr);
      @(posedge clk);
      #1;
      if (!reset) begin
        pend_q.delete();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end else if (pend_q.size() > 0 && (auto_rsp || rel_used < rel_cnt)) begin
        if (!auto_rsp) rel_used++;
        bus.imem_rdata  = mdata(pend_q.pop_front());
        bus.imem_rvalid = 1'b1;
        if (lat_mode) rv_cyc_q.push_back(cyc);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
    end
  end

  // Decode ready: held level or toggling every cycle.
  initial begin
    bus.inst_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.inst_ready = toggle_mode ? ~bus.inst_ready : rdy_level;
    end
  end

  // Monitor: compare the offered head against the scoreboard front.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      prev_stall = 1'b0;
      mdl_cnt    = 0;
    end else begin
      if (prev_stall && !bus.flush) chk("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
      if (bus.inst_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_inst: got pc %h required no instruction", bus.inst_pc);
        end else begin
          chk(bus.inst_ready ? "pop_pc" : "stall_pc", bus.inst_pc, exp_q[0].pc);
          chk(bus.inst_ready ? "pop_data" : "stall_data", bus.inst_data, exp_q[0].data);
          if (bus.inst_ready) begin
            void'(exp_q.pop_front());
            if (lat_mode && rv_cyc_q.size() > 0) chk("latency", cyc, rv_cyc_q.pop_front() + 1);
          end
        end
      end
      prev_stall = bus.inst_valid & ~bus.inst_ready;
      if (bus.flush) mdl_cnt = 0;
      else begin
        if (bus.fetch_ready) begin
          mdl_cnt++;
          chk("count_bound", {31'd0, (mdl_cnt <= DEPTH)}, 32'd1);
        end
        if (bus.inst_valid && bus.inst_ready) mdl_cnt--;
      end
    end
  end

  task automatic release_rsp(input int n);
    rel_cnt = rel_used + n;
  endtask

  // Present an address until accepted; optionally expect it at decode.
  task automatic issue(input logic [31:0] a, input bit expect_it);
    bit got;
    exp_t e;
    got = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = a;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.fetch_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL accept_timeout: got no fetch_ready required accept of %h", a);
    end else begin
      chk("imem_addr", bus.imem_addr, {a[31:2], 2'b00});
      if (expect_it) begin
        e.pc   = a;
        e.data = mdata({a[31:2], 2'b00});
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.fetch_valid = 1'b0;
  endtask

  // Wait (bounded) for every expected instruction to be delivered.
  task automatic drain(input string name);
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (4) @(negedge clk);
    chk(name, exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_imem_req"},    {31'd0, bus.imem_req},    32'd0);
    chk({tag, "_fetch_ready"}, {31'd0, bus.fetch_ready}, 32'd0);
    chk({tag, "_inst_valid"},  {31'd0, bus.inst_valid},  32'd0);
    chk({tag, "_inst_data"},   bus.inst_data,            32'd0);
    chk({tag, "_inst_pc"},     bus.inst_pc,              32'd0);
    chk({tag, "_imem_addr"},   bus.imem_addr,            32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h1234_5677;

    // Reset state, with a fetch presented to prove it is ignored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("rst");
    @(posedge clk);
    #1;
    bus.fetch_valid = 1'b0;
    reset = 1'b1;

    // Streaming, one-cycle memory, decode always ready.
    rdy_level = 1'b1;
    lat_mode  = 1'b1;
    @(posedge clk);
    #1;
    issue(32'h0, 1'b1);
    issue(32'h4, 1'b1);
    issue(32'h8, 1'b1);
    drain("stream_drain");
    lat_mode = 1'b0;
    rv_cyc_q.delete();

    // Full: decode stalled, four accepts then no request.
    rdy_level = 1'b0;
    @(posedge clk);
    #1;
    issue(32'h0, 1'b1);
    issue(32'h4, 1'b1);
    issue(32'h8, 1'b1);
    issue(32'hC, 1'b1);
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h10;
    repeat (4) begin
      @(negedge clk);
      chk("full_imem_req", {31'd0, bus.imem_req}, 32'd0);
      chk("full_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
    end
    rdy_level = 1'b1;
    issue(32'h10, 1'b1);
    issue(32'h14, 1'b1);
    drain("full_drain");

    // Flush with three fetches in flight; their responses must be dropped.
    auto_rsp = 1'b0;
    issue(32'h10, 1'b0);
    issue(32'h14, 1'b0);
    issue(32'h18, 1'b0);
    bus.flush       = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h100;
    @(negedge clk);
    chk("flush_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("flush_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    issue(32'h100, 1'b1);
    release_rsp(4);
    drain("flush_drain");

    // Flush coinciding with a response: exactly one later response dropped.
    issue(32'h40, 1'b0);
    issue(32'h44, 1'b0);
    @(negedge clk);
    release_rsp(1);
    @(posedge clk);
    #1;
    bus.flush       = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h48;
    @(negedge clk);
    chk("flush2_imem_req", {31'd0, bus.imem_req}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    issue(32'h48, 1'b1);
    release_rsp(10);
    drain("flush_rsp_drain");
    auto_rsp = 1'b1;

    // Back-pressure with ready toggling, across pointer wrap.
    toggle_mode = 1'b1;
    for (int i = 0; i < 10; i++) issue(32'h200 + 32'(4 * i), 1'b1);
    drain("wrap_drain");
    toggle_mode = 1'b0;

    // Asynchronous reset with two queued entries and one outstanding fetch.
    rdy_level = 1'b0;
    @(posedge clk);
    #1;
    auto_rsp = 1'b0;
    issue(32'h300, 1'b1);
    issue(32'h304, 1'b1);
    issue(32'h308, 1'b0);
    release_rsp(2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    reset           = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h400;
    #1;
    chk_quiet("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    bus.fetch_valid = 1'b0;
    reset = 1'b1;
    auto_rsp  = 1'b1;
    rdy_level = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", {31'd0, bus.inst_valid}, 32'd0);
    @(posedge clk);
    #1;
    issue(32'h0, 1'b1);
    issue(32'h503, 1'b1);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
